// File: rtl/rcr_pkg.sv
// Shared types and constants for the ripple counter reader.
package rcr_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] AMBIG_DIFF = 4'd8;

  typedef enum logic {
    INIT,
    TRACK
  } state_e;

  // A modulo-16 difference in the upper half is a down step, so sign-extending
  // the raw difference gives the two's-complement step directly.
  function automatic logic [CNT_W:0] step_delta(input logic [CNT_W-1:0] diff);
    return {diff[CNT_W-1], diff};
  endfunction

endpackage

// File: rtl/rcr_sync.sv
// Single-bit multi-flop synchroniser feeding one bit of the ripple count.
module rcr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_cnt_reader.sv
// Reads an asynchronous ripple up/down counter: synchronise, debounce, then track steps.
// Optional err_cnt output is enabled by defining RIPPLE_CNT_READER_ERRCNT_EN.
module ripple_cnt_reader
  import rcr_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             upd,
  output logic             dir,
  output logic [CNT_W:0]   delta,
  output logic             err
`ifdef RIPPLE_CNT_READER_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [3:0] STAB_MAX  = 4'(STABLE_CYCLES);
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES);

  logic [CNT_W-1:0] sync_s;
  logic [2:0]       warm_q, warm_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic [3:0]       stab_q, stab_d;
  logic             stable;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             valid_q, valid_d;
  logic             upd_q, upd_d;
  logic             dir_q, dir_d;
  logic [CNT_W:0]   delta_q, delta_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] diff;

  for (genvar i = 0; i < CNT_W; i++) begin : g_sync
    rcr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (cnt_in[i]),
      .q_o (sync_s[i])
    );
  end

  // The filter stays idle until the synchroniser has flushed its reset zeros,
  // otherwise a stale 0 would be accepted as the first value after reset.
  always_comb begin
    warm_d = warm_q;
    cand_d = cand_q;
    stab_d = stab_q;
    if (warm_q != WARM_DONE) begin
      warm_d = warm_q + 3'd1;
    end else if (sync_s != cand_q) begin
      cand_d = sync_s;
      stab_d = 4'd1;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 4'd1;
    end
  end

  assign stable = (stab_q == STAB_MAX);
  assign diff   = cand_q - cnt_out_q;

  always_comb begin
    state_d   = state_q;
    cnt_out_d = cnt_out_q;
    valid_d   = valid_q;
    dir_d     = dir_q;
    delta_d   = delta_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      INIT: begin
        if (stable) begin
          cnt_out_d = cand_q;
          valid_d   = 1'b1;
          state_d   = TRACK;
        end
      end
      TRACK: begin
        if (stable && diff != '0) begin
          cnt_out_d = cand_q;
          if (diff == AMBIG_DIFF) begin
            err_d = 1'b1;
          end else begin
            upd_d   = 1'b1;
            dir_d   = ~diff[CNT_W-1];
            delta_d = step_delta(diff);
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_q    <= '0;
      cand_q    <= '0;
      stab_q    <= '0;
      state_q   <= INIT;
      cnt_out_q <= '0;
      valid_q   <= 1'b0;
      upd_q     <= 1'b0;
      dir_q     <= 1'b0;
      delta_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      warm_q    <= warm_d;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      state_q   <= state_d;
      cnt_out_q <= cnt_out_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      dir_q     <= dir_d;
      delta_q   <= delta_d;
      err_q     <= err_d;
    end
  end

  assign cnt_out   = cnt_out_q;
  assign cnt_valid = valid_q;
  assign upd       = upd_q;
  assign dir       = dir_q;
  assign delta     = delta_q;
  assign err       = err_q;

`ifdef RIPPLE_CNT_READER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             err_cnt_q <= '0;
    else if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ripple_cnt_reader.sv
// Self-checking bench for ripple_cnt_reader: directed scenarios plus a random walk
// compared against a window-based reference model.
module tb_ripple_cnt_reader;

  localparam int SYNC = 2;
  localparam int STAB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = 4'd3;
  logic [3:0] cnt_out;
  logic       cnt_valid, upd, dir, err;
  logic [4:0] delta;
`ifdef RIPPLE_CNT_READER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  ripple_cnt_reader #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .upd       (upd),
    .dir       (dir),
    .delta     (delta),
    .err       (err)
`ifdef RIPPLE_CNT_READER_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a value is accepted once it has been seen on cnt_in for
  // STAB consecutive edges, SYNC edges in the past; -1 marks reset edges.
  int         hist[$];
  logic [3:0] mOut;
  logic       mValid, mUpd, mDir, mErr;
  logic [4:0] mDelta;
  int         mErrCnt;

  function automatic void model_clear();
    hist.delete();
    mOut = 0; mValid = 0; mUpd = 0; mDir = 0; mErr = 0; mDelta = 0; mErrCnt = 0;
  endfunction

  function automatic void model_edge(int sample);
    int m, lo, v, diff;
    bit same;
    mUpd = 0;
    mErr = 0;
    if (sample < 0) begin
      model_clear();
      hist.push_back(-1);
      return;
    end
    hist.push_back(sample);
    m  = hist.size() - 1;
    lo = m - SYNC - STAB;
    if (lo < 0) return;
    v = hist[lo];
    same = (v >= 0);
    for (int k = lo + 1; k <= m - SYNC - 1; k++) if (hist[k] != v) same = 0;
    if (!same) return;
    if (!mValid) begin
      mOut = 4'(v);
      mValid = 1;
    end else if (v != int'(mOut)) begin
      diff = (v - int'(mOut) + 16) % 16;
      mOut = 4'(v);
      if (diff == 8) begin
        mErr = 1;
        if (mErrCnt < 255) mErrCnt++;
      end else begin
        mUpd = 1;
        mDir = (diff < 8);
        mDelta = 5'(diff < 8 ? diff : diff - 16);
      end
    end
  endfunction

  task automatic cycle(input logic [3:0] v);
    cnt_in = v;
    @(posedge clk);
    model_edge(rst ? -1 : int'(v));
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] v, input int n, output int nUpd, output int nErr);
    nUpd = 0;
    nErr = 0;
    for (int i = 0; i < n; i++) begin
      cycle(v);
      nUpd += int'(upd);
      nErr += int'(err);
    end
  endtask

  task automatic test_reset();
    int u1, e1, u2, e2, u3, e3;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) cycle(4'd3);
    vectors++;
    if ({cnt_valid, cnt_out, upd, dir, delta, err} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {cnt_valid, cnt_out, upd, dir, delta, err});
    end
`ifdef RIPPLE_CNT_READER_ERRCNT_EN
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt);
    end
`endif
    rst = 1'b0;
    hold(4'd3, 4, u1, e1);
    vectors++;
    if (cnt_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_early_valid: got %b expected 0", cnt_valid);
    end
    hold(4'd3, 1, u2, e2);
    vectors++;
    if ({cnt_valid, cnt_out} !== {1'b1, 4'd3}) begin
      miscompares++;
      $display("[TB] FAIL release_publish: got valid=%b out=%0d expected valid=1 out=3", cnt_valid, cnt_out);
    end
    hold(4'd3, 5, u3, e3);
    vectors++;
    if (u1 + u2 + u3 != 0 || e1 + e2 + e3 != 0) begin
      miscompares++;
      $display("[TB] FAIL release_pulses: got upd=%0d err=%0d expected 0 0", u1 + u2 + u3, e1 + e2 + e3);
    end
  endtask

  task automatic test_up_ramp();
    int nUpd, nErr;
    logic [3:0] v;
    for (int k = 0; k < 13; k++) begin
      v = 4'(4 + k);
      hold(v, 10, nUpd, nErr);
      vectors++;
      if (nUpd != 1 || nErr != 0 || cnt_out !== v || dir !== 1'b1 || delta !== 5'd1) begin
        miscompares++;
        $display("[TB] FAIL up_step_%0d: got upd=%0d err=%0d out=%0d dir=%b delta=%b expected 1 0 %0d 1 00001",
                 v, nUpd, nErr, cnt_out, dir, delta, v);
      end
    end
  endtask

  task automatic test_down_ramp();
    int nUpd, nErr;
    logic [3:0] v;
    hold(4'd2, 10, nUpd, nErr);
    vectors++;
    if (nUpd != 1 || cnt_out !== 4'd2 || dir !== 1'b1 || delta !== 5'd2) begin
      miscompares++;
      $display("[TB] FAIL down_start: got upd=%0d out=%0d dir=%b delta=%b expected 1 2 1 00010", nUpd, cnt_out, dir, delta);
    end
    for (int k = 1; k <= 3; k++) begin
      v = 4'(2 - k);
      hold(v, 10, nUpd, nErr);
      vectors++;
      if (nUpd != 1 || nErr != 0 || cnt_out !== v || dir !== 1'b0 || delta !== 5'b11111) begin
        miscompares++;
        $display("[TB] FAIL down_step_%0d: got upd=%0d err=%0d out=%0d dir=%b delta=%b expected 1 0 %0d 0 11111",
                 v, nUpd, nErr, cnt_out, dir, delta, v);
      end
    end
  endtask

  task automatic test_ambiguous();
    int nUpd, nErr;
    hold(4'd2, 10, nUpd, nErr);
    vectors++;
    if (nUpd != 1 || cnt_out !== 4'd2 || dir !== 1'b1 || delta !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL ambig_setup: got upd=%0d out=%0d dir=%b delta=%b expected 1 2 1 00011", nUpd, cnt_out, dir, delta);
    end
    hold(4'd10, 10, nUpd, nErr);
    vectors++;
    if (nErr != 1 || nUpd != 0 || cnt_out !== 4'd10 || dir !== 1'b1 || delta !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL ambig_step: got err=%0d upd=%0d out=%0d dir=%b delta=%b expected 1 0 10 1 00011",
               nErr, nUpd, cnt_out, dir, delta);
    end
`ifdef RIPPLE_CNT_READER_ERRCNT_EN
    vectors++;
    if (err_cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL ambig_err_cnt: got %0d expected 1", err_cnt);
    end
`endif
  endtask

  task automatic test_glitch();
    int nUpd, nErr;
    hold(4'd7, 10, nUpd, nErr);
    vectors++;
    if (nUpd != 1 || cnt_out !== 4'd7 || dir !== 1'b0 || delta !== 5'b11101) begin
      miscompares++;
      $display("[TB] FAIL glitch_setup: got upd=%0d out=%0d dir=%b delta=%b expected 1 7 0 11101", nUpd, cnt_out, dir, delta);
    end
    cycle(4'd6);
    hold(4'd7, 10, nUpd, nErr);
    vectors++;
    if (nUpd != 0 || nErr != 0 || cnt_out !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL glitch_filtered: got upd=%0d err=%0d out=%0d expected 0 0 7", nUpd, nErr, cnt_out);
    end
    hold(4'd4, 10, nUpd, nErr);
    vectors++;
    if (nUpd != 1 || cnt_out !== 4'd4 || dir !== 1'b0 || delta !== 5'b11101) begin
      miscompares++;
      $display("[TB] FAIL glitch_minus3: got upd=%0d out=%0d dir=%b delta=%b expected 1 4 0 11101", nUpd, cnt_out, dir, delta);
    end
  endtask

  task automatic test_reset_midfilter();
    int u1, e1, u2, e2, u3, e3;
    hold(4'd5, 10, u1, e1);
    cycle(4'd6);
    cycle(4'd6);
    rst = 1'b1;
    model_clear();
    #1;
    vectors++;
    if ({cnt_valid, cnt_out, upd, dir, delta, err} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %b expected 0", {cnt_valid, cnt_out, upd, dir, delta, err});
    end
`ifdef RIPPLE_CNT_READER_ERRCNT_EN
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_err_cnt: got %0d expected 0", err_cnt);
    end
`endif
    @(negedge clk);
    cycle(4'd6);
    cycle(4'd6);
    rst = 1'b0;
    hold(4'd6, 4, u1, e1);
    vectors++;
    if (cnt_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_early_valid: got %b expected 0", cnt_valid);
    end
    hold(4'd6, 1, u2, e2);
    vectors++;
    if ({cnt_valid, cnt_out} !== {1'b1, 4'd6}) begin
      miscompares++;
      $display("[TB] FAIL midreset_publish: got valid=%b out=%0d expected valid=1 out=6", cnt_valid, cnt_out);
    end
    hold(4'd6, 5, u3, e3);
    vectors++;
    if (u1 + u2 + u3 != 0 || e1 + e2 + e3 != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_pulses: got upd=%0d err=%0d expected 0 0", u1 + u2 + u3, e1 + e2 + e3);
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    logic [3:0] step;
    int         holdLen;
    v = cnt_in;
    for (int i = 0; i < 80; i++) begin
      step = 4'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       v = 4'($urandom_range(0, 15));
        1:       v = v - step;
        default: v = v + step;
      endcase
      holdLen = $urandom_range(1, 8);
      for (int h = 0; h < holdLen; h++) begin
        cycle(v);
        vectors++;
        if ({cnt_valid, cnt_out, upd, dir, delta, err} !== {mValid, mOut, mUpd, mDir, mDelta, mErr}) begin
          miscompares++;
          $display("[TB] FAIL random_%0d_%0d: got v=%b out=%0d upd=%b dir=%b delta=%b err=%b expected v=%b out=%0d upd=%b dir=%b delta=%b err=%b",
                   i, h, cnt_valid, cnt_out, upd, dir, delta, err, mValid, mOut, mUpd, mDir, mDelta, mErr);
        end
`ifdef RIPPLE_CNT_READER_ERRCNT_EN
        vectors++;
        if (err_cnt !== 8'(mErrCnt)) begin
          miscompares++;
          $display("[TB] FAIL random_err_cnt_%0d_%0d: got %0d expected %0d", i, h, err_cnt, mErrCnt);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_ambiguous();
    test_glitch();
    test_reset_midfilter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
